uart_tx_shift_register: RTL and testbench

Transmit shift register (TSR) of the UART transmit path. It sits directly downstream of the transmitter timing controller: it captures a character on `load_data`, serialises it onto the TX line as start, data, optional parity and stop bits while `shift_tsr` is asserted, and reports `tsr_busy` back to the controller. `BCLK` is the 16x baud clock, so every serial bit lasts 16 shift-enabled `BCLK` cycles.

---
 rtl/uart_tx_shift_register.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_shift_register.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_shift_register.sv
// UART transmit shift register: captures a character and serialises start, data,
// optional parity and stop bits, each lasting OVERSAMPLE shift-enabled BCLK cycles.
module uart_tx_shift_register #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       BCLK,
  input  logic       RST,
  input  logic       load_data,
  input  logic       shift_tsr,
  input  logic [7:0] thr_data,
  input  logic [4:0] lcr,
  output logic       tx,
  output logic       tsr_busy,
  output logic       tx_done
);
  // state  | meaning
  // IDLE   | no frame, tx high
  // LOADED | character latched, waiting for first shift enable
  // START  | start bit, tx low
  // DATA   | data bits, LSB first
  // PARITY | parity bit
  // STOP   | one or two stop bits, tx high

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    wl_q, wl_d;
  logic          stop2_q, stop2_d;
  logic          par_en_q, par_en_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    data_masked;
  logic [2:0]    last_bit;
  logic          bit_end;

  // Bits above the selected word length are dropped at capture time
  assign data_masked = thr_data & (8'hFF >> (2'd3 - lcr[1:0]));
  assign last_bit    = {1'b0, wl_q} + 3'd4;
  assign bit_end     = shift_tsr && (tick_q == TICK_LAST);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    data_d   = data_q;
    wl_d     = wl_q;
    stop2_d  = stop2_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_data) begin
          state_d  = LOADED;
          data_d   = data_masked;
          wl_d     = lcr[1:0];
          stop2_d  = lcr[2];
          par_en_d = lcr[3];
          par_d    = (^data_masked) ^ ~lcr[4];
        end
      end
      LOADED: begin
        if (shift_tsr) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (shift_tsr) begin
          tick_d = bit_end ? '0 : tick_q + TW'(1);
        end
        if (bit_end) begin
          case (state_q)
            START: begin
              state_d = DATA;
              bit_d   = 3'd0;
            end
            DATA: begin
              if (bit_q == last_bit) begin
                state_d = par_en_q ? PARITY : STOP;
                stop_d  = 1'b0;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
            PARITY: begin
              state_d = STOP;
              stop_d  = 1'b0;
            end
            default: begin
              if (stop_q == stop2_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                stop_d = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_d];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge BCLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      wl_q     <= '0;
      stop2_q  <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      wl_q     <= wl_d;
      stop2_q  <= stop2_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tsr_busy = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_shift_register.sv
// Self-checking bench for uart_tx_shift_register: directed frame table, corner-case
// sequences and randomized traffic against a sample-queue reference model.
`timescale 1ns/1ps
module tb_uart_tx_shift_register;
  logic       BCLK = 1'b0;
  logic       RST = 1'b1;
  logic       load_data = 1'b0;
  logic       shift_tsr = 1'b0;
  logic [7:0] thr_data = 8'h00;
  logic [4:0] lcr = 5'b00000;
  logic       tx, tsr_busy, tx_done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  uart_tx_shift_register #(.OVERSAMPLE(16)) dut (
    .BCLK      (BCLK),
    .RST       (RST),
    .load_data (load_data),
    .shift_tsr (shift_tsr),
    .thr_data  (thr_data),
    .lcr       (lcr),
    .tx        (tx),
    .tsr_busy  (tsr_busy),
    .tx_done   (tx_done)
  );

  always #5 BCLK = ~BCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of per-cycle tx samples built from the line rules
  logic m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;
  bit   m_started = 1'b0;
  logic [7:0] m_data;
  logic [4:0] m_lcr;
  bit   m_q[$];

  function automatic void build_frame();
    bit bits[$];
    int wl;
    bit p;
    wl = int'(m_lcr[1:0]) + 5;
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < wl; i++) begin
      bits.push_back(m_data[i]);
      p = p ^ m_data[i];
    end
    if (m_lcr[3]) bits.push_back(m_lcr[4] ? p : ~p);
    bits.push_back(1'b1);
    if (m_lcr[2]) bits.push_back(1'b1);
    m_q.delete();
    foreach (bits[i]) for (int c = 0; c < 16; c++) m_q.push_back(bits[i]);
  endfunction

  always @(posedge BCLK) begin
    m_done = 1'b0;
    if (RST) begin
      m_q.delete();
      m_busy = 1'b0;
      m_started = 1'b0;
      m_tx = 1'b1;
    end else if (!m_busy) begin
      if (load_data) begin
        m_busy = 1'b1;
        m_data = thr_data;
        m_lcr  = lcr;
      end
    end else if (!m_started) begin
      if (shift_tsr) begin
        build_frame();
        m_started = 1'b1;
        m_tx = m_q.pop_front();
      end
    end else if (shift_tsr) begin
      if (m_q.size() > 0) begin
        m_tx = m_q.pop_front();
      end else begin
        m_busy = 1'b0;
        m_started = 1'b0;
        m_tx = 1'b1;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge BCLK) begin
    if (chk_en) begin
      check("model_tx", tx, m_tx);
      check("model_busy", tsr_busy, m_busy);
      check("model_done", tx_done, m_done);
    end
  end

  // seq: first transmitted bit in [11], nb bits used
  typedef struct {
    logic [4:0]  lcr;
    logic [7:0]  data;
    logic [11:0] seq;
    int          nb;
  } vec_t;

  vec_t vecs[5];

  // Caller must be at a negedge; load is applied immediately (back-to-back capable)
  task automatic run_frame(input vec_t v);
    load_data = 1'b1;
    lcr = v.lcr;
    thr_data = v.data;
    @(negedge BCLK);
    load_data = 1'b0;
    shift_tsr = 1'b1;
    check("busy_rise", tsr_busy, 1);
    check("tx_loaded", tx, 1);
    for (int b = 0; b < v.nb; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge BCLK);
        check("frame_bit", tx, v.seq[11-b]);
      end
    end
    @(negedge BCLK);
    check("busy_fall", tsr_busy, 0);
    check("done_pulse", tx_done, 1);
  endtask

  initial begin
    int k;
    vecs[0] = '{lcr: 5'b00011, data: 8'hA5, seq: 12'b0101_0010_1100, nb: 10};
    vecs[1] = '{lcr: 5'b11110, data: 8'hD5, seq: 12'b0101_0101_0110, nb: 11};
    vecs[2] = '{lcr: 5'b01000, data: 8'h3F, seq: 12'b0111_1101_0000, nb: 8};
    vecs[3] = '{lcr: 5'b00101, data: 8'h2C, seq: 12'b0001_1011_1000, nb: 9};
    vecs[4] = '{lcr: 5'b00011, data: 8'h5A, seq: 12'b0010_1101_0100, nb: 10};

    repeat (3) @(negedge BCLK);
    check("rst_tx", tx, 1);
    check("rst_busy", tsr_busy, 0);
    check("rst_done", tx_done, 0);
    RST = 1'b0;
    chk_en = 1'b1;

    // Table frames, each loaded in the cycle the previous one drops busy
    for (int i = 0; i < 4; i++) run_frame(vecs[i]);
    @(negedge BCLK);
    check("done_one_cycle", tx_done, 0);
    shift_tsr = 1'b0;

    // Pause 10 cycles inside data bit 3 of 8N1 0x37, with an ignored reload
    load_data = 1'b1; lcr = 5'b00011; thr_data = 8'h37;
    @(negedge BCLK);
    load_data = 1'b0; shift_tsr = 1'b1;
    k = 0;
    repeat (70) begin @(negedge BCLK); k++; end
    shift_tsr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin load_data = 1'b1; thr_data = 8'h00; lcr = 5'b00000; end
      if (i == 3) load_data = 1'b0;
      @(negedge BCLK); k++;
      check("pause_tx_hold", tx, 0);
    end
    shift_tsr = 1'b1;
    while (tsr_busy && k < 400) begin @(negedge BCLK); k++; end
    check("pause_busy_fall_cycle", k, 171);

    // Reset during data bits aborts the frame without tx_done
    load_data = 1'b1; lcr = 5'b00011; thr_data = 8'hFF;
    @(negedge BCLK);
    load_data = 1'b0;
    repeat (40) @(negedge BCLK);
    RST = 1'b1;
    @(negedge BCLK);
    RST = 1'b0;
    check("abort_tx", tx, 1);
    check("abort_busy", tsr_busy, 0);
    check("abort_done", tx_done, 0);
    k = 0;
    repeat (20) begin @(negedge BCLK); if (tx_done) k++; end
    check("abort_no_done", k, 0);
    run_frame(vecs[4]);

    // load and shift together in IDLE: LOADED only, then a full 16-cycle start bit
    @(negedge BCLK);
    load_data = 1'b1; shift_tsr = 1'b1; lcr = 5'b00011; thr_data = 8'hFF;
    @(negedge BCLK);
    load_data = 1'b0;
    check("ls_busy", tsr_busy, 1);
    check("ls_tx_idle_high", tx, 1);
    k = 0;
    repeat (16) begin @(negedge BCLK); if (tx == 1'b0) k++; end
    check("ls_start_len", k, 16);
    @(negedge BCLK);
    check("ls_data0", tx, 1);
    k = 0;
    while (tsr_busy && k < 400) begin @(negedge BCLK); k++; end
    check("ls_finish", tsr_busy, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 8000; n++) begin
      RST       = ($urandom_range(0, 599) == 0);
      load_data = ($urandom_range(0, 7) == 0);
      shift_tsr = ($urandom_range(0, 3) != 0);
      thr_data  = 8'($urandom);
      lcr       = 5'($urandom);
      @(negedge BCLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
